// File: rtl/ct_result_collector.sv
// ct_result_collector: captures the four result beats of a 2x2 convolution
// job, presents them as a registered matrix with its unsigned max-pool value,
// and holds them under a valid/ready handshake. Protocol faults (too few or
// too many beats, or a job that never finishes) park the block in ERR.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for en_ct; beats and ct_done ignored
// ARMED   | job started, waiting for the first beat; ct_done ignored
// COLLECT | capturing beats 2..4, waiting for ct_done
// HOLD    | result valid, waiting for res_ready
// ERR     | protocol error latched; only en_ct or reset leaves
module ct_result_collector #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_ct,
   input  logic              ct_en_result,
   input  logic [DATA_W-1:0] ct_result,
   input  logic              ct_done,
   input  logic              res_ready,
   output logic [DATA_W-1:0] c_1_1,
   output logic [DATA_W-1:0] c_1_2,
   output logic [DATA_W-1:0] c_2_1,
   output logic [DATA_W-1:0] c_2_2,
   output logic [DATA_W-1:0] pool_max,
   output logic              res_valid,
   output logic              busy,
   output logic              rx_error,
   output logic [2:0]        rx_count
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_COLLECT = 3'd2,
      S_HOLD    = 3'd3,
      S_ERR     = 3'd4
   } state_t;

   state_t                       state_q, state_d;
   logic [2:0]                   rx_count_q, rx_count_d;
   logic [TMR_W-1:0]             tmr_q, tmr_d;
   logic [3:0][DATA_W-1:0]       shadow_q, shadow_d;
   logic [3:0][DATA_W-1:0]       mat_q, mat_d;
   logic [DATA_W-1:0]            pool_q, pool_d;

   logic [DATA_W-1:0]            max_01, max_23, max_all;
   logic                         tmr_tc;

   // Unsigned max over the shadow slots, used when the result is committed.
   always_comb begin
      max_01  = (shadow_q[0] >= shadow_q[1]) ? shadow_q[0] : shadow_q[1];
      max_23  = (shadow_q[2] >= shadow_q[3]) ? shadow_q[2] : shadow_q[3];
      max_all = (max_01 >= max_23) ? max_01 : max_23;
   end

   // Next-state, beat capture, result commit and timeout down-counter.
   always_comb begin
      state_d    = state_q;
      rx_count_d = rx_count_q;
      tmr_d      = tmr_q;
      shadow_d   = shadow_q;
      mat_d      = mat_q;
      pool_d     = pool_q;
      // Terminal count: this edge would be the TIMEOUT-th since arming.
      tmr_tc     = (tmr_q == TMR_W'(1));

      if (en_ct) begin
         state_d    = S_ARMED;
         rx_count_d = 3'd0;
         tmr_d      = TMR_W'(TIMEOUT);
      end else begin
         case (state_q)
            S_ARMED: begin
               tmr_d = tmr_q - TMR_W'(1);
               if (ct_en_result) begin
                  shadow_d[0] = ct_result;
                  rx_count_d  = 3'd1;
                  state_d     = S_COLLECT;
               end
               if (tmr_tc) state_d = S_ERR;
            end
            S_COLLECT: begin
               tmr_d = tmr_q - TMR_W'(1);
               if (ct_done) begin
                  if (ct_en_result || (rx_count_q != 3'd4)) begin
                     state_d = S_ERR;
                  end else begin
                     state_d = S_HOLD;
                     mat_d   = shadow_q;
                     pool_d  = max_all;
                  end
               end else if (ct_en_result) begin
                  if (rx_count_q == 3'd4) begin
                     state_d = S_ERR;
                  end else begin
                     shadow_d[rx_count_q[1:0]] = ct_result;
                     rx_count_d                = rx_count_q + 3'd1;
                  end
               end
               // A commit on the terminal edge still wins over the timeout.
               if (tmr_tc && (state_d != S_HOLD)) state_d = S_ERR;
            end
            S_HOLD: begin
               if (res_ready) state_d = S_IDLE;
            end
            default: begin
            end
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         rx_count_q <= 3'd0;
         tmr_q      <= '0;
         shadow_q   <= '0;
         mat_q      <= '0;
         pool_q     <= '0;
      end else begin
         state_q    <= state_d;
         rx_count_q <= rx_count_d;
         tmr_q      <= tmr_d;
         shadow_q   <= shadow_d;
         mat_q      <= mat_d;
         pool_q     <= pool_d;
      end
   end

   assign c_1_1     = mat_q[0];
   assign c_1_2     = mat_q[1];
   assign c_2_1     = mat_q[2];
   assign c_2_2     = mat_q[3];
   assign pool_max  = pool_q;
   assign rx_count  = rx_count_q;
   assign res_valid = (state_q == S_HOLD);
   assign busy      = (state_q == S_ARMED) || (state_q == S_COLLECT);
   assign rx_error  = (state_q == S_ERR);

endmodule

// File: doc/ct_result_collector.md
CT_RESULT_COLLECTOR -- requirements
Module: ct_result_collector

Interface
REQ-001 Parameter DATA_W, 8, width of each result beat and matrix element.
REQ-002 Parameter TIMEOUT, 32, maximum cycles from en_ct to ct_done before error.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset; all registers cleared immediately while low.
REQ-005 en_ct  in  1  start strobe, the same signal that starts the convolution controller; arms the collector.
REQ-006 ct_en_result  in  1  result-beat qualifier from the controller.
REQ-007 ct_result  in  DATA_W  result beat, in order c_1_1, c_1_2, c_2_1, c_2_2.
REQ-008 ct_done  in  1  end-of-job level from the controller; stays high until the controller restarts.
REQ-009 c_1_1, c_1_2, c_2_1, c_2_2  out  DATA_W each  registered 2x2 output matrix.
REQ-010 pool_max  out  DATA_W  registered unsigned maximum of the four elements.
REQ-011 res_valid  out  1  matrix and pool_max are valid; held until accepted.
REQ-012 res_ready  in  1  downstream accept; a transfer occurs on any edge where res_valid=1 and res_ready=1.
REQ-013 busy  out  1  high in ARMED and COLLECT.
REQ-014 rx_error  out  1  sticky protocol-error flag.
REQ-015 rx_count  out  3  number of beats captured in the current job, 0..4.

Function
REQ-016 States: IDLE, ARMED, COLLECT, HOLD, ERR; encoding is free; the state register resets to IDLE.
REQ-017 en_ct=1 in any state -> ARMED next edge; rx_count, timeout counter and rx_error cleared; res_valid dropped; any held result discarded; en_ct takes priority over every other event on that edge.
REQ-018 ARMED: ct_done ignored; ct_en_result=1 -> beat stored in shadow slot 0, rx_count=1, -> COLLECT.
REQ-019 COLLECT: ct_en_result=1 with rx_count<4 -> beat stored in shadow slot rx_count, rx_count+1.
REQ-020 COLLECT: ct_en_result=1 with rx_count==4 (overflow) -> beat dropped, -> ERR.
REQ-021 COLLECT: ct_done=1, ct_en_result=0, rx_count==4 -> HOLD next edge; on that edge c_* load from shadow slots 0..3, pool_max loads the unsigned max of the four slots, and res_valid=1.
REQ-022 COLLECT: ct_done=1 with rx_count!=4 (underflow), or ct_done=1 together with ct_en_result=1 -> ERR.
REQ-023 Timeout counter runs in ARMED and COLLECT only; the counter reaches TIMEOUT without a HOLD transition -> ERR.
REQ-024 HOLD: c_*, pool_max and res_valid stay stable; ct_done level and ct_en_result ignored; res_ready=1 -> res_valid=0, -> IDLE on the same edge.
REQ-025 HOLD with en_ct=1 and res_ready=1 on the same edge: the transfer completes and the state goes to ARMED.
REQ-026 ERR: rx_error=1; res_valid=0; c_* and pool_max keep their last values; exit only by en_ct or reset.
REQ-027 IDLE: ct_en_result and ct_done ignored; rx_count keeps its last value.
REQ-028 Output latency from the edge sampling ct_done to res_valid=1 is one edge.
REQ-029 The max compare is unsigned, DATA_W bits; ties yield that value; no arithmetic widening.

Reset
REQ-030 reset=0 forces state IDLE; all c_*, pool_max, rx_count and the timeout counter become 0; res_valid, busy and rx_error become 0.
REQ-031 Reset asserted mid-job (ARMED, COLLECT or HOLD) discards all data; after release, the block waits for en_ct.
REQ-032 Reset release is sampled by the first posedge clk after deassertion; there are no outputs that depend combinationally on inputs.

Verification
REQ-033 Nominal: en_ct, 17 idle cycles, beats 8'h12,8'h34,8'h56,8'h07, ct_done next cycle -> res_valid=1 one edge later, c_1_1=12, c_1_2=34, c_2_1=56, c_2_2=07, pool_max=56.
REQ-034 Backpressure: res_ready=0 for 5 cycles, then 1 -> outputs stable for 5 cycles, res_valid falls on the accepting edge, ct_done still high does not retrigger.
REQ-035 Underflow: 3 beats then ct_done -> rx_error=1, rx_count=3, res_valid stays 0; en_ct then clears rx_error.
REQ-036 Overflow and timeout: 5 consecutive beats -> ERR; separately, en_ct with no ct_done for 32 cycles -> rx_error=1.
REQ-037 Restart: en_ct after the second beat, followed by a full nominal sequence -> only the new four values appear; pool_max is correct for all-8'hFF (FF) and all-zero (00) data.
REQ-038 Async reset: reset=0 between edges during COLLECT -> all outputs 0 immediately without a clock edge; the first job after release completes nominally.
